// File: rtl/agc_timepulse_seq.sv
// -----------------------------------------------------------------------------
// agc_timepulse_seq
//
// Timepulse sequencer for the NOR-gate datapath. The master clock is divided
// into memory cycle times (MCTs); each MCT walks NPULSE one-hot timepulses
// (T01..Tnn), and each timepulse lasts PHASES clocks. The sequencer supports
// continuous running, halting at an MCT boundary, single-MCT stepping from
// halt, and a GOJAM restart of the current MCT.
//
// Ports:
//   clk        in   system clock (only clock)
//   rst_n      in   synchronous active-low reset
//   start      in   level: request continuous running (IDLE/HALT -> RUN)
//   stop       in   request halt at the end of the current MCT
//   step       in   from HALT, run exactly one MCT then halt again
//   gojam      in   restart the running MCT at T01, phase 0
//   tp         out  one-hot timepulse, bit 0 = T01; all-zero while halted
//   phase      out  sub-phase index within the current timepulse
//   mct_end    out  high in the final clock of the final timepulse
//   halted     out  sequencer idle or halted
//   mct_count  out  completed MCTs, wraps modulo 2^CW
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module agc_timepulse_seq #(
    parameter int NPULSE = 12,  // 2..16
    parameter int PHASES = 2,   // 1..8
    parameter int CW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              gojam,
    output logic [NPULSE-1:0] tp,
    output logic [2:0]        phase,
    output logic              mct_end,
    output logic              halted,
    output logic [CW-1:0]     mct_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [2:0]        PH_LAST = 3'(PHASES - 1);
    localparam logic [NPULSE-1:0] TP_T01  = NPULSE'(1);

    state_e              state_q,     state_d;
    logic [NPULSE-1:0]   tp_q,        tp_d;
    logic [2:0]          phase_q,     phase_d;
    logic                mct_end_q,   mct_end_d;
    logic                halted_q,    halted_d;
    logic [CW-1:0]       count_q,     count_d;
    logic                stop_pend_q, stop_pend_d;
    logic                step_mode_q, step_mode_d;

    logic                last_phase;
    logic                at_boundary;

    assign last_phase  = (phase_q == PH_LAST);
    assign at_boundary = tp_q[NPULSE-1] && last_phase;

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so no path can leave
        // it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        tp_d        = tp_q;
        phase_d     = phase_q;
        count_d     = count_q;
        stop_pend_d = stop_pend_q;
        step_mode_d = step_mode_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    tp_d        = TP_T01;
                    phase_d     = 3'd0;
                    step_mode_d = 1'b0;
                end
            end

            ST_HALT: begin
                // start beats step when both are sampled together.
                if (start) begin
                    state_d     = ST_RUN;
                    tp_d        = TP_T01;
                    phase_d     = 3'd0;
                    step_mode_d = 1'b0;
                end else if (step) begin
                    state_d     = ST_RUN;
                    tp_d        = TP_T01;
                    phase_d     = 3'd0;
                    step_mode_d = 1'b1;
                end
            end

            ST_RUN: begin
                // A stop request is remembered until the next boundary.
                if (stop) begin
                    stop_pend_d = 1'b1;
                end

                if (gojam) begin
                    // Abort this MCT without counting it; pending halt and
                    // step mode carry over to the restarted MCT.
                    tp_d    = TP_T01;
                    phase_d = 3'd0;
                end else if (at_boundary) begin
                    count_d = count_q + CW'(1);
                    if (stop_pend_q || stop || step_mode_q) begin
                        state_d     = ST_HALT;
                        tp_d        = '0;
                        phase_d     = 3'd0;
                        stop_pend_d = 1'b0;
                        step_mode_d = 1'b0;
                    end else begin
                        tp_d    = TP_T01;
                        phase_d = 3'd0;
                    end
                end else if (last_phase) begin
                    // Never reaches the top bit here: that case is the boundary.
                    tp_d    = tp_q << 1;
                    phase_d = 3'd0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                tp_d        = '0;
                phase_d     = 3'd0;
                stop_pend_d = 1'b0;
                step_mode_d = 1'b0;
            end
        endcase

        // Flags derived from the next state so they line up with tp/phase.
        halted_d  = (state_d != ST_RUN);
        mct_end_d = (state_d == ST_RUN) && tp_d[NPULSE-1] && (phase_d == PH_LAST);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tp_q        <= '0;
            phase_q     <= 3'd0;
            mct_end_q   <= 1'b0;
            halted_q    <= 1'b1;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tp_q        <= tp_d;
            phase_q     <= phase_d;
            mct_end_q   <= mct_end_d;
            halted_q    <= halted_d;
            count_q     <= count_d;
            stop_pend_q <= stop_pend_d;
            step_mode_q <= step_mode_d;
        end
    end

    assign tp        = tp_q;
    assign phase     = phase_q;
    assign mct_end   = mct_end_q;
    assign halted    = halted_q;
    assign mct_count = count_q;

endmodule

// File: tb/tb_agc_timepulse_seq.sv
// -----------------------------------------------------------------------------
// tb_agc_timepulse_seq
//
// Two sequencers share one stimulus stream: u0 with the default geometry
// (12 pulses x 2 phases, 16-bit count) and u1 with 4 pulses x 1 phase and a
// 2-bit count. A reference model tracks each one as "running or not" plus a
// clock index into the MCT, and every cycle its predicted outputs are compared
// with both DUTs. Literal expectations at key points pin the model down.
// -----------------------------------------------------------------------------
module tb_agc_timepulse_seq;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, step, gojam;

    logic [11:0] tp0;
    logic [2:0]  phase0;
    logic        mct_end0, halted0;
    logic [15:0] count0;

    logic [3:0]  tp1;
    logic [2:0]  phase1;
    logic        mct_end1, halted1;
    logic [1:0]  count1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    agc_timepulse_seq #(.NPULSE(12), .PHASES(2), .CW(16)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
        .gojam(gojam), .tp(tp0), .phase(phase0), .mct_end(mct_end0),
        .halted(halted0), .mct_count(count0)
    );

    agc_timepulse_seq #(.NPULSE(4), .PHASES(1), .CW(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
        .gojam(gojam), .tp(tp1), .phase(phase1), .mct_end(mct_end1),
        .halted(halted1), .mct_count(count1)
    );

    // ---------------- reference model ----------------
    localparam int NP  [2] = '{12, 4};
    localparam int PH  [2] = '{2, 1};
    localparam int CWV [2] = '{16, 2};

    bit m_run  [2];  // running an MCT
    bit m_ever [2];  // has left IDLE since reset (step only works from HALT)
    bit m_sp   [2];  // stop requested
    bit m_sm   [2];  // single-MCT step in progress
    int m_k    [2];  // clock index within the MCT, 0 .. NP*PH-1
    int m_cnt  [2];  // completed MCTs (unwrapped)

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int last;
            last = NP[i] * PH[i] - 1;
            if (!rst_n) begin
                m_run[i] = 0; m_ever[i] = 0; m_sp[i] = 0; m_sm[i] = 0;
                m_k[i] = 0; m_cnt[i] = 0;
            end else if (m_run[i]) begin
                if (stop) m_sp[i] = 1;
                if (gojam) begin
                    m_k[i] = 0;
                end else if (m_k[i] == last) begin
                    m_cnt[i]++;
                    if (m_sp[i] || m_sm[i]) begin
                        m_run[i] = 0; m_sp[i] = 0; m_sm[i] = 0; m_k[i] = 0;
                    end else begin
                        m_k[i] = 0;
                    end
                end else begin
                    m_k[i]++;
                end
            end else if (start) begin
                m_run[i] = 1; m_ever[i] = 1; m_sm[i] = 0; m_k[i] = 0;
            end else if (step && m_ever[i]) begin
                m_run[i] = 1; m_sm[i] = 1; m_k[i] = 0;
            end
        end
    endtask

    task automatic model_compare();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] e_tp, e_ph, e_end, e_hlt, e_cnt;
            logic [31:0] a_tp, a_ph, a_end, a_hlt, a_cnt;
            e_tp  = m_run[i] ? (32'd1 << (m_k[i] / PH[i])) : 32'd0;
            e_ph  = m_run[i] ? 32'(m_k[i] % PH[i]) : 32'd0;
            e_end = 32'(m_run[i] && (m_k[i] == NP[i] * PH[i] - 1));
            e_hlt = 32'(!m_run[i]);
            e_cnt = 32'(m_cnt[i] % (1 << CWV[i]));
            if (i == 0) begin
                a_tp = 32'(tp0); a_ph = 32'(phase0); a_end = 32'(mct_end0);
                a_hlt = 32'(halted0); a_cnt = 32'(count0);
            end else begin
                a_tp = 32'(tp1); a_ph = 32'(phase1); a_end = 32'(mct_end1);
                a_hlt = 32'(halted1); a_cnt = 32'(count1);
            end
            check($sformatf("u%0d.tp", i),        a_tp,  e_tp);
            check($sformatf("u%0d.phase", i),     a_ph,  e_ph);
            check($sformatf("u%0d.mct_end", i),   a_end, e_end);
            check($sformatf("u%0d.halted", i),    a_hlt, e_hlt);
            check($sformatf("u%0d.mct_count", i), a_cnt, e_cnt);
        end
    endtask

    // Advance n clocks: model follows each edge, outputs checked mid-cycle.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
            model_compare();
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int exp_c [5];
        exp_c = '{1, 2, 3, 0, 1};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; gojam = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("reset tp",      32'(tp0), 32'h0);
        check("reset phase",   32'(phase0), 32'h0);
        check("reset halted",  32'(halted0), 32'h1);
        check("reset mct_end", 32'(mct_end0), 32'h0);
        check("reset count",   32'(count0), 32'h0);

        // Start: T01 one clock later, boundary at clock 24, wrap at clock 25.
        start = 1'b1; tick(1); start = 1'b0;
        check("start T01",    32'(tp0), 32'h001);
        check("start halted", 32'(halted0), 32'h0);
        tick(23);
        check("clk24 tp",      32'(tp0), 32'h800);
        check("clk24 phase",   32'(phase0), 32'h1);
        check("clk24 mct_end", 32'(mct_end0), 32'h1);
        tick(1);
        check("clk25 tp",    32'(tp0), 32'h001);
        check("clk25 count", 32'(count0), 32'h1);

        // stop during T05 (index 8): completes the MCT, then halts.
        tick(8);
        check("T05 tp", 32'(tp0), 32'h010);
        stop = 1'b1; tick(1); stop = 1'b0;
        tick(14);
        check("stop mct_end", 32'(mct_end0), 32'h1);
        tick(1);
        check("stop halted", 32'(halted0), 32'h1);
        check("stop tp",     32'(tp0), 32'h0);
        check("stop count",  32'(count0), 32'h2);
        stop = 1'b1; tick(1); stop = 1'b0; tick(2);
        check("halt ignores stop", 32'(halted0), 32'h1);

        // step held 3 clocks: exactly one MCT.
        step = 1'b1; tick(1);
        check("step T01", 32'(tp0), 32'h001);
        tick(2); step = 1'b0;
        tick(21);
        check("step mct_end", 32'(mct_end0), 32'h1);
        tick(1);
        check("step halted", 32'(halted0), 32'h1);
        check("step count",  32'(count0), 32'h3);
        tick(3);
        check("no second MCT", 32'(halted0), 32'h1);

        // gojam during T07 phase 1 (index 13).
        start = 1'b1; tick(1); start = 1'b0;
        tick(13);
        check("T07 tp",    32'(tp0), 32'h040);
        check("T07 phase", 32'(phase0), 32'h1);
        gojam = 1'b1; tick(1); gojam = 1'b0;
        check("gojam tp",    32'(tp0), 32'h001);
        check("gojam phase", 32'(phase0), 32'h0);
        check("gojam count", 32'(count0), 32'h3);
        tick(23);
        check("post-gojam mct_end", 32'(mct_end0), 32'h1);
        tick(1);
        check("post-gojam count", 32'(count0), 32'h4);

        // Reset during T09 (index 16): immediate abort; start needed again.
        tick(16);
        check("T09 tp", 32'(tp0), 32'h100);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        check("mid reset tp",     32'(tp0), 32'h0);
        check("mid reset count",  32'(count0), 32'h0);
        check("mid reset halted", 32'(halted0), 32'h1);
        tick(3);
        check("idle stays", 32'(halted0), 32'h1);

        // u1 (4 pulses, 1 phase, CW=2): five continuous MCTs.
        start = 1'b1; tick(1); start = 1'b0;
        for (int m = 0; m < 5; m++) begin
            tick(3);
            check($sformatf("u1 mct_end %0d", m), 32'(mct_end1), 32'h1);
            tick(1);
            check($sformatf("u1 count %0d", m), 32'(count1), 32'(exp_c[m]));
        end

        // u0: stop pending, then gojam on the boundary clock restarts the MCT
        // and the halt lands at the end of the restarted one.
        stop = 1'b1; tick(1); stop = 1'b0;
        tick(2);
        check("pend mct_end", 32'(mct_end0), 32'h1);
        gojam = 1'b1; tick(1); gojam = 1'b0;
        check("pend gojam tp",    32'(tp0), 32'h001);
        check("pend gojam count", 32'(count0), 32'h0);
        tick(23);
        check("pend restart end", 32'(mct_end0), 32'h1);
        tick(1);
        check("pend halted", 32'(halted0), 32'h1);
        check("pend count",  32'(count0), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
